// File: rtl/jtframe_dwnld_split_if.sv
// Download-path bus between the HPS ioctl side and the byte splitter.
// The master modport is the HPS/download side, the slave modport is the splitter.
interface jtframe_dwnld_split_if #(
  parameter int INW  = 16,
  parameter int DIPW = 32
);
  // download side: one word per dwnld_wr pulse
  logic            downloading;
  logic            dwnld_wr;
  logic [26:0]     dwnld_addr;
  logic [INW-1:0]  dwnld_data;
  logic [7:0]      dwnld_index;

  // ROM loader side: one byte per ioctl_wr pulse
  logic            ioctl_wr;
  logic            ioctl_rom_wr;
  logic [24:0]     ioctl_addr;
  logic [7:0]      ioctl_data;
  logic [7:0]      ioctl_index;
  logic [DIPW-1:0] dipsw;
  logic [6:0]      core_mod;
  logic            busy;
  logic            overflow;

  modport master (
    output downloading, dwnld_wr, dwnld_addr, dwnld_data, dwnld_index,
    input  ioctl_wr, ioctl_rom_wr, ioctl_addr, ioctl_data, ioctl_index,
    input  dipsw, core_mod, busy, overflow
  );

  modport slave (
    input  downloading, dwnld_wr, dwnld_addr, dwnld_data, dwnld_index,
    output ioctl_wr, ioctl_rom_wr, ioctl_addr, ioctl_data, ioctl_index,
    output dipsw, core_mod, busy, overflow
  );
endinterface

// File: rtl/jtframe_dwnld_split.sv
// Splits INW-bit download words into little-endian byte writes spaced GAP
// clk_rom cycles apart. A one-entry skid buffer holds a word that arrives
// while a split is running; a word arriving with the skid occupied is
// dropped and flagged in the sticky overflow bit. Bytes are routed by index
// to the ROM write strobe, the DIP-switch register or the core_mod register.
module jtframe_dwnld_split #(
  parameter int              INW     = 16,
  parameter int              GAP     = 24,
  parameter int              DIPW    = 32,
  parameter logic [DIPW-1:0] DIP_DEF = {DIPW{1'b0}},
  parameter logic [7:0]      ROM_IDX = 8'd0,
  parameter logic [7:0]      MOD_IDX = 8'd1,
  parameter logic [7:0]      DIP_IDX = 8'd254
)(
  input  logic                clk_rom,
  input  logic                rst,
  jtframe_dwnld_split_if.slave bus
);

  localparam int NB = INW / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int DB = DIPW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAPW = 2'd2
  } state_t;

  // engine state and working word
  state_t          state_r;
  logic [KW-1:0]   k_r;
  logic [GW-1:0]   gap_cnt_r;
  logic [24:0]     w_addr_r;
  logic [INW-1:0]  w_data_r;
  logic [7:0]      w_idx_r;

  // skid buffer
  logic            skid_full_r;
  logic [24:0]     skid_addr_r;
  logic [INW-1:0]  skid_data_r;
  logic [7:0]      skid_idx_r;

  // registered outputs and edge detector
  logic            dl_r;
  logic            ioctl_wr_r;
  logic            ioctl_rom_wr_r;
  logic [24:0]     ioctl_addr_r;
  logic [7:0]      ioctl_data_r;
  logic [7:0]      ioctl_index_r;
  logic [DIPW-1:0] dipsw_r;
  logic [6:0]      core_mod_r;
  logic            busy_r;
  logic            overflow_r;

  // step decisions
  logic            last_s;
  logic            gap_done_s;
  logic            adv_s;
  logic            fin_s;
  logic            take_skid_s;
  logic            take_in_s;
  logic            emit_s;
  logic            store_s;
  logic            drop_s;
  logic            busy_nxt_s;

  // byte about to be presented
  logic [24:0]     src_addr_s;
  logic [INW-1:0]  src_data_s;
  logic [7:0]      src_idx_s;
  logic [KW-1:0]   em_k_s;
  logic [24:0]     em_addr_s;
  logic [7:0]      em_byte_s;

  // the two top address bits have no destination on the 25-bit ROM bus
  logic            unused_s;
  assign unused_s = ^bus.dwnld_addr[26:25];

  // little-endian byte k of a word
  function automatic logic [7:0] byte_sel(input logic [INW-1:0] d, input logic [KW-1:0] k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (k == KW'(i)) begin
        b = d[8*i +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // decide what the engine does on the coming edge and which byte it shows
  always_comb begin
    last_s     = (k_r == KW'(NB - 1));
    gap_done_s = 1'b0;
    case (state_r)
      ST_EMIT: gap_done_s = (GAP == 1);
      ST_GAPW: gap_done_s = (gap_cnt_r == GW'(1));
      default: gap_done_s = 1'b0;
    endcase
    adv_s       = gap_done_s & ~last_s;
    fin_s       = gap_done_s & last_s;
    take_skid_s = fin_s & skid_full_r;
    // a word arriving as the engine finishes goes straight in
    take_in_s   = bus.dwnld_wr & ((state_r == ST_IDLE) | (fin_s & ~skid_full_r));
    emit_s      = adv_s | take_skid_s | take_in_s;
    store_s     = bus.dwnld_wr & ~take_in_s & ~skid_full_r;
    drop_s      = bus.dwnld_wr & ~take_in_s & skid_full_r;

    if (take_in_s) begin
      src_addr_s = bus.dwnld_addr[24:0];
      src_data_s = bus.dwnld_data;
      src_idx_s  = bus.dwnld_index;
      em_k_s     = {KW{1'b0}};
    end else if (take_skid_s) begin
      src_addr_s = skid_addr_r;
      src_data_s = skid_data_r;
      src_idx_s  = skid_idx_r;
      em_k_s     = {KW{1'b0}};
    end else begin
      src_addr_s = w_addr_r;
      src_data_s = w_data_r;
      src_idx_s  = w_idx_r;
      em_k_s     = k_r + KW'(1'b1);
    end
    // full 25-bit add so a word straddling the top of the space wraps to 0
    em_addr_s = src_addr_s + 25'(em_k_s);
    em_byte_s = byte_sel(src_data_s, em_k_s);

    busy_nxt_s = emit_s | ((state_r != ST_IDLE) & ~fin_s) |
                 (skid_full_r & ~take_skid_s) | store_s;
  end

  // split engine, skid buffer, index routing and status flags
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      k_r            <= {KW{1'b0}};
      gap_cnt_r      <= {GW{1'b0}};
      w_addr_r       <= 25'd0;
      w_data_r       <= {INW{1'b0}};
      w_idx_r        <= 8'd0;
      skid_full_r    <= 1'b0;
      skid_addr_r    <= 25'd0;
      skid_data_r    <= {INW{1'b0}};
      skid_idx_r     <= 8'd0;
      dl_r           <= 1'b0;
      ioctl_wr_r     <= 1'b0;
      ioctl_rom_wr_r <= 1'b0;
      ioctl_addr_r   <= 25'd0;
      ioctl_data_r   <= 8'd0;
      ioctl_index_r  <= 8'd0;
      dipsw_r        <= DIP_DEF;
      core_mod_r     <= 7'h7F;
      busy_r         <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      ioctl_wr_r     <= 1'b0;
      ioctl_rom_wr_r <= 1'b0;
      dl_r           <= bus.downloading;
      busy_r         <= busy_nxt_s;

      if (emit_s) begin
        state_r        <= ST_EMIT;
        k_r            <= em_k_s;
        w_addr_r       <= src_addr_s;
        w_data_r       <= src_data_s;
        w_idx_r        <= src_idx_s;
        ioctl_wr_r     <= 1'b1;
        ioctl_rom_wr_r <= (src_idx_s == ROM_IDX);
        ioctl_addr_r   <= em_addr_s;
        ioctl_data_r   <= em_byte_s;
        ioctl_index_r  <= src_idx_s;
        if (src_idx_s == DIP_IDX && em_addr_s < 25'(DB)) begin
          for (int i = 0; i < DB; i++) begin
            if (em_addr_s == 25'(i)) begin
              dipsw_r[8*i +: 8] <= em_byte_s;
            end
          end
        end
        if (src_idx_s == MOD_IDX) begin
          core_mod_r <= em_byte_s[6:0];
        end
      end else if (fin_s) begin
        state_r <= ST_IDLE;
      end else if (state_r == ST_EMIT) begin
        state_r   <= ST_GAPW;
        gap_cnt_r <= GW'(GAP - 1);
      end else if (state_r == ST_GAPW) begin
        gap_cnt_r <= gap_cnt_r - GW'(1'b1);
      end else begin
        state_r <= ST_IDLE;
      end

      if (take_skid_s) begin
        skid_full_r <= 1'b0;
      end else if (store_s) begin
        skid_full_r <= 1'b1;
        skid_addr_r <= bus.dwnld_addr[24:0];
        skid_data_r <= bus.dwnld_data;
        skid_idx_r  <= bus.dwnld_index;
      end

      // a lost word wins over a simultaneous restart of the download
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (bus.downloading & ~dl_r) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign bus.ioctl_wr     = ioctl_wr_r;
  assign bus.ioctl_rom_wr = ioctl_rom_wr_r;
  assign bus.ioctl_addr   = ioctl_addr_r;
  assign bus.ioctl_data   = ioctl_data_r;
  assign bus.ioctl_index  = ioctl_index_r;
  assign bus.dipsw        = dipsw_r;
  assign bus.core_mod     = core_mod_r;
  assign bus.busy         = busy_r;
  assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_jtframe_dwnld_split.sv
// Bench for jtframe_dwnld_split: a 16-bit/GAP=24 instance (a) and a
// 32-bit/GAP=4 instance (b) driven by directed and random words. The
// reference model schedules each accepted word as a list of byte times
// (start + j*GAP) and derives every output from that schedule.
module tb_jtframe_dwnld_split;

  localparam logic [31:0] DEF_A = 32'h1234_5678;
  localparam logic [31:0] DEF_B = 32'hCAFE_F00D;

  logic clk_rom = 1'b0;
  logic rst;

  always #5 clk_rom = ~clk_rom;

  jtframe_dwnld_split_if #(.INW(16), .DIPW(32)) ifa ();
  jtframe_dwnld_split_if #(.INW(32), .DIPW(32)) ifb ();

  jtframe_dwnld_split #(.INW(16), .GAP(24), .DIPW(32), .DIP_DEF(DEF_A)) u_dut_a (
    .clk_rom (clk_rom),
    .rst     (rst),
    .bus     (ifa)
  );

  jtframe_dwnld_split #(.INW(32), .GAP(4), .DIPW(32), .DIP_DEF(DEF_B)) u_dut_b (
    .clk_rom (clk_rom),
    .rst     (rst),
    .bus     (ifb)
  );

  typedef struct {
    int          inst;
    longint      start;
    logic [24:0] addr;
    logic [31:0] data;
    logic [7:0]  idx;
  } word_t;

  word_t       wq[$];
  longint      ecnt;
  longint      sched_end[2];
  longint      last_start[2];
  logic        ovf_m[2];
  logic        dlp_m[2];
  logic [31:0] dip_m[2];
  logic [6:0]  mod_m[2];
  logic        exp_wr[2];
  logic        exp_rom[2];
  logic        exp_busy[2];
  logic [24:0] exp_addr[2];
  logic [7:0]  exp_data[2];
  logic [7:0]  exp_idx[2];

  logic        wr_v[2];
  logic [26:0] addr_v[2];
  logic [31:0] data_v[2];
  logic [7:0]  idx_v[2];
  logic        dl_v[2];

  int n_chk;
  int n_fail;

  function automatic int nb_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 24 : 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sched_end[i]  = 0;
      last_start[i] = -1;
      ovf_m[i]      = 1'b0;
      dlp_m[i]      = 1'b0;
      dip_m[i]      = (i == 0) ? DEF_A : DEF_B;
      mod_m[i]      = 7'h7F;
      exp_wr[i]     = 1'b0;
      exp_rom[i]    = 1'b0;
      exp_busy[i]   = 1'b0;
      exp_addr[i]   = 25'd0;
      exp_data[i]   = 8'd0;
      exp_idx[i]    = 8'd0;
    end
    wq.delete();
  endtask

  // what instance i does at edge number ecnt given the inputs now driven
  task automatic model_step(input int i);
    longint e;
    int     nb;
    int     gp;
    logic   drop;
    word_t  w;
    e    = ecnt;
    nb   = nb_of(i);
    gp   = gap_of(i);
    drop = 1'b0;
    if (wr_v[i]) begin
      w.inst = i;
      w.addr = addr_v[i][24:0];
      w.data = (i == 0) ? {16'h0000, data_v[i][15:0]} : data_v[i];
      w.idx  = idx_v[i];
      if (e >= sched_end[i]) begin
        w.start = e;
        wq.push_back(w);
        last_start[i] = e;
        sched_end[i]  = e + nb * gp;
      end else if (last_start[i] >= e) begin
        drop = 1'b1;
      end else begin
        w.start = sched_end[i];
        wq.push_back(w);
        last_start[i] = w.start;
        sched_end[i]  = w.start + nb * gp;
      end
    end
    if (drop) ovf_m[i] = 1'b1;
    else if (dl_v[i] && !dlp_m[i]) ovf_m[i] = 1'b0;
    dlp_m[i] = dl_v[i];

    exp_wr[i]  = 1'b0;
    exp_rom[i] = 1'b0;
    for (int q = 0; q < wq.size(); q++) begin
      if (wq[q].inst == i && e >= wq[q].start && ((e - wq[q].start) % gp) == 0 &&
          ((e - wq[q].start) / gp) < nb) begin
        int          j;
        logic [7:0]  b;
        logic [24:0] a;
        j = int'((e - wq[q].start) / gp);
        b = 8'((wq[q].data >> (8 * j)) & 32'h0000_00FF);
        a = wq[q].addr + 25'(j);
        exp_wr[i]   = 1'b1;
        exp_rom[i]  = (wq[q].idx == 8'd0);
        exp_addr[i] = a;
        exp_data[i] = b;
        exp_idx[i]  = wq[q].idx;
        if (wq[q].idx == 8'd254 && a < 25'd4)
          dip_m[i] = (dip_m[i] & ~(32'h0000_00FF << (8 * int'(a)))) | ({24'h0, b} << (8 * int'(a)));
        if (wq[q].idx == 8'd1)
          mod_m[i] = b[6:0];
      end
    end
    for (int q = wq.size() - 1; q >= 0; q--) begin
      if (wq[q].inst == i && e >= wq[q].start + (nb - 1) * gp) wq.delete(q);
    end
    exp_busy[i] = (e < sched_end[i]);
  endtask

  task automatic check_outputs(input int i);
    string       p;
    logic        g_wr, g_rom, g_busy, g_ovf;
    logic [24:0] g_addr;
    logic [7:0]  g_data, g_idx;
    logic [31:0] g_dip;
    logic [6:0]  g_mod;
    if (i == 0) begin
      p = "a"; g_wr = ifa.ioctl_wr; g_rom = ifa.ioctl_rom_wr; g_busy = ifa.busy; g_ovf = ifa.overflow;
      g_addr = ifa.ioctl_addr; g_data = ifa.ioctl_data; g_idx = ifa.ioctl_index;
      g_dip = ifa.dipsw; g_mod = ifa.core_mod;
    end else begin
      p = "b"; g_wr = ifb.ioctl_wr; g_rom = ifb.ioctl_rom_wr; g_busy = ifb.busy; g_ovf = ifb.overflow;
      g_addr = ifb.ioctl_addr; g_data = ifb.ioctl_data; g_idx = ifb.ioctl_index;
      g_dip = ifb.dipsw; g_mod = ifb.core_mod;
    end
    chk({p, ".ioctl_wr"}, 64'(g_wr), 64'(exp_wr[i]));
    chk({p, ".ioctl_rom_wr"}, 64'(g_rom), 64'(exp_rom[i]));
    chk({p, ".busy"}, 64'(g_busy), 64'(exp_busy[i]));
    chk({p, ".overflow"}, 64'(g_ovf), 64'(ovf_m[i]));
    chk({p, ".dipsw"}, 64'(g_dip), 64'(dip_m[i]));
    chk({p, ".core_mod"}, 64'(g_mod), 64'(mod_m[i]));
    if (exp_wr[i]) begin
      chk({p, ".ioctl_addr"}, 64'(g_addr), 64'(exp_addr[i]));
      chk({p, ".ioctl_data"}, 64'(g_data), 64'(exp_data[i]));
      chk({p, ".ioctl_index"}, 64'(g_idx), 64'(exp_idx[i]));
    end
  endtask

  task automatic send(input int i, input logic [26:0] a, input logic [31:0] d, input logic [7:0] x);
    wr_v[i]   = 1'b1;
    addr_v[i] = a;
    data_v[i] = d;
    idx_v[i]  = x;
  endtask

  // one clock: drive, predict, clock, compare
  task automatic cycle();
    ifa.dwnld_wr    = wr_v[0];
    ifa.dwnld_addr  = addr_v[0];
    ifa.dwnld_data  = data_v[0][15:0];
    ifa.dwnld_index = idx_v[0];
    ifa.downloading = dl_v[0];
    ifb.dwnld_wr    = wr_v[1];
    ifb.dwnld_addr  = addr_v[1];
    ifb.dwnld_data  = data_v[1];
    ifb.dwnld_index = idx_v[1];
    ifb.downloading = dl_v[1];
    model_step(0);
    model_step(1);
    @(posedge clk_rom);
    #1;
    check_outputs(0);
    check_outputs(1);
    ecnt++;
    wr_v[0] = 1'b0;
    wr_v[1] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  function automatic logic [7:0] rand_idx();
    logic [1:0] s;
    s = 2'($urandom_range(0, 3));
    case (s)
      2'd0:    return 8'd0;
      2'd1:    return 8'd1;
      2'd2:    return 8'd254;
      default: return 8'h37;
    endcase
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ecnt   = 0;
    for (int i = 0; i < 2; i++) begin
      wr_v[i] = 1'b0; addr_v[i] = 27'd0; data_v[i] = 32'd0; idx_v[i] = 8'd0; dl_v[i] = 1'b1;
    end
    ifa.dwnld_wr = 1'b0; ifa.dwnld_addr = 27'd0; ifa.dwnld_data = 16'd0; ifa.dwnld_index = 8'd0;
    ifa.downloading = 1'b1;
    ifb.dwnld_wr = 1'b0; ifb.dwnld_addr = 27'd0; ifb.dwnld_data = 32'd0; ifb.dwnld_index = 8'd0;
    ifb.downloading = 1'b1;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_rom);
    #1;
    chk("rst.a.ioctl_addr", 64'(ifa.ioctl_addr), 64'd0);
    chk("rst.a.ioctl_data", 64'(ifa.ioctl_data), 64'd0);
    chk("rst.a.ioctl_index", 64'(ifa.ioctl_index), 64'd0);
    chk("rst.b.ioctl_addr", 64'(ifb.ioctl_addr), 64'd0);
    chk("rst.a.dipsw", 64'(ifa.dipsw), 64'(DEF_A));
    chk("rst.b.core_mod", 64'(ifb.core_mod), 64'h7F);
    @(negedge clk_rom);
    rst = 1'b0;
    idle(3);

    // first word on each; b gets a second word into the skid two cycles later;
    // a gets a second word exactly as its engine finishes
    send(0, 27'h100, 32'h0000_BEEF, 8'd0);
    send(1, 27'h0, 32'h1122_3344, 8'd0);
    cycle();
    cycle();
    send(1, 27'h4, 32'h5566_7788, 8'd0);
    cycle();
    idle(45);
    send(0, 27'h200, 32'h0000_1357, 8'h07);
    cycle();
    idle(60);

    // three back-to-back words: third is lost; overflow survives a falling
    // edge of downloading and clears on the next rising edge
    for (int n = 0; n < 3; n++) begin
      send(0, 27'h300 + 27'(2 * n), 32'h0000_A000 + 32'(n), 8'd0);
      cycle();
    end
    idle(2);
    dl_v[0] = 1'b0;
    idle(5);
    dl_v[0] = 1'b1;
    idle(100);

    // DIP capture: in-range and out-of-range addresses
    send(0, 27'h2, 32'h0000_C3A5, 8'd254);
    cycle();
    idle(47);
    send(0, 27'h4, 32'h0000_5A00, 8'd254);
    cycle();
    idle(50);

    // core_mod capture, last byte wins
    send(0, 27'h0, 32'h0000_8300, 8'd1);
    cycle();
    idle(50);

    // reset in the middle of a 32-bit word after two bytes
    send(1, 27'h40, 32'h0102_0304, 8'd1);
    cycle();
    idle(4);
    rst = 1'b1;
    #2;
    chk("arst.b.ioctl_wr", 64'(ifb.ioctl_wr), 64'd0);
    chk("arst.b.busy", 64'(ifb.busy), 64'd0);
    chk("arst.b.core_mod", 64'(ifb.core_mod), 64'h7F);
    chk("arst.b.dipsw", 64'(ifb.dipsw), 64'(DEF_B));
    model_reset();
    repeat (2) @(posedge clk_rom);
    @(negedge clk_rom);
    rst = 1'b0;
    idle(20);

    // address wrap at the top of the 25-bit space; upper bits ignored
    send(0, 27'h1FF_FFFF, 32'h0000_6BD2, 8'd0);
    send(1, 27'h7FF_FFFE, 32'h8899_AABB, 8'd0);
    cycle();
    idle(50);

    // random traffic, sparse then dense
    for (int r = 0; r < 3000; r++) begin
      for (int i = 0; i < 2; i++) begin
        int dens;
        dens = (r < 1500) ? ((i == 0) ? 3 : 8) : ((i == 0) ? 8 : 25);
        if (int'($urandom_range(0, 99)) < dens) begin
          logic [26:0] a;
          a = ($urandom_range(0, 1) == 0) ? 27'($urandom_range(0, 7)) : 27'($urandom);
          send(i, a, $urandom, rand_idx());
        end
      end
      cycle();
    end
    idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
